gauss5_window_ctrl: RTL and testbench



---
 rtl/gauss_pkg.sv | 45 ++++
 rtl/gauss_line_ram.sv | 44 ++++
 rtl/gauss5_window_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_gauss5_window_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// gauss_pkg
// Shared definitions for the 5x5 Gaussian window front end.
//   rgb888_t          pixel layout {R[23:16], G[15:8], B[7:0]}
//   win_state_t       window controller states
//   GAUSS_PIC_*       default picture geometry
//   GAUSS_K/GAUSS_DIV normalised 5x5 kernel used by the downstream filter
// Optional build macro: GAUSS_FLUSH_EN adds the FLUSH state.

package gauss_pkg;

    localparam int GAUSS_PIC_WIDTH  = 480;
    localparam int GAUSS_PIC_HEIGHT = 272;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

`ifdef GAUSS_FLUSH_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } win_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } win_state_t;
`endif

    // Kernel weights sum to GAUSS_DIV.
    localparam int GAUSS_DIV = 273;
    localparam logic [5:0] GAUSS_K [5][5] = '{
        '{6'd1, 6'd4,  6'd7,  6'd4,  6'd1},
        '{6'd4, 6'd16, 6'd26, 6'd16, 6'd4},
        '{6'd7, 6'd26, 6'd41, 6'd26, 6'd7},
        '{6'd4, 6'd16, 6'd26, 6'd16, 6'd4},
        '{6'd1, 6'd4,  6'd7,  6'd4,  6'd1}
    };

endpackage

// File: rtl/gauss_line_ram.sv
// gauss_line_ram
// Single-clock, read-first dual-port line buffer (WIDTH x DEPTH).
//   clk, rst_n   clock / async active-low reset (output register only)
//   re, raddr    read enable and address; rdata holds between reads
//   we, waddr    write enable and address
//   wdata        write data
//   rdata        registered read data; returns old contents on a
//                same-address read/write
// The memory array itself is not reset.

module gauss_line_ram
    import gauss_pkg::*;
#(
    parameter int WIDTH = $bits(rgb888_t),
    parameter int DEPTH = GAUSS_PIC_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gauss5_window_ctrl.sv
// gauss5_window_ctrl
// Front-end sequencer for the 5x5 Gaussian window datapath. Buffers four
// lines in a rotating ring of line RAMs and presents five vertically
// aligned taps per accepted column, one cycle after acceptance.
//   clk, rst_n          clock / async active-low reset
//   s_valid/s_ready     pixel stream handshake (accept = s_valid & s_ready)
//   s_data, s_sof       pixel and start-of-frame marker
//   tap_valid           din1..din5 hold one new column (shift enable)
//   din1..din5          rows r-4 .. r of the tapped column
//   win_valid           tap completes a fully supported 5x5 window
//   win_row, win_col    window centre, zero when win_valid is low
//   frame_done          one-cycle pulse at end of frame
//   sync_err            one-cycle pulse on an unexpected s_sof
// Optional build macro: GAUSS_FLUSH_EN (zero-padded bottom flush).
//
// state | meaning
// IDLE  | waiting for s_sof, other pixels are dropped
// FILL  | rows 0..3, priming the line ring
// RUN   | rows 4..H-1, windows emitted
// FLUSH | (GAUSS_FLUSH_EN) two virtual zero rows, s_ready low

module gauss5_window_ctrl
    import gauss_pkg::*;
#(
    parameter int WIDTH      = $bits(rgb888_t),
    parameter int PIC_WIDTH  = GAUSS_PIC_WIDTH,
    parameter int PIC_HEIGHT = GAUSS_PIC_HEIGHT,
    parameter int CW         = $clog2(PIC_WIDTH),
    parameter int RW         = $clog2(PIC_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sof,
    output logic             tap_valid,
    output logic [WIDTH-1:0] din1,
    output logic [WIDTH-1:0] din2,
    output logic [WIDTH-1:0] din3,
    output logic [WIDTH-1:0] din4,
    output logic [WIDTH-1:0] din5,
    output logic             win_valid,
    output logic [RW-1:0]    win_row,
    output logic [CW-1:0]    win_col,
    output logic             frame_done,
    output logic             sync_err
);

    // One extra row bit so the virtual flush rows H and H+1 never alias.
    localparam int RXW = RW + 1;

    localparam logic [CW-1:0]  COL_LAST       = CW'(PIC_WIDTH - 1);
    localparam logic [CW-1:0]  COL_WIN_MIN    = CW'(4);
    localparam logic [RXW-1:0] ROW_FILL_LAST  = RXW'(3);
    localparam logic [RXW-1:0] ROW_LAST       = RXW'(PIC_HEIGHT - 1);
    localparam logic [RXW-1:0] ROW_WIN_MIN    = RXW'(4);
`ifdef GAUSS_FLUSH_EN
    localparam logic [RXW-1:0] ROW_FLUSH_LAST = RXW'(PIC_HEIGHT + 1);
`endif

    win_state_t       state, state_n, eff_state;
    logic [RXW-1:0]   row, row_n, eff_row;
    logic [CW-1:0]    col, col_n, eff_col;
    logic [1:0]       wp, wp_n, eff_wp, tap_wp;

    logic             acc;
    logic             step;
    logic             restart;
    logic             err_n;
    logic             done_n;
    logic             col_last;
    logic             win_n;
    logic [WIDTH-1:0] pix;
    logic [RW-1:0]    cen_row;
    logic [CW-1:0]    cen_col;
    logic [WIDTH-1:0] rd_data [4];

`ifdef GAUSS_FLUSH_EN
    assign s_ready = (state != ST_FLUSH);
`else
    assign s_ready = 1'b1;
`endif

    assign acc = s_valid & s_ready;

    always_comb begin
        step    = 1'b0;
        restart = 1'b0;
        err_n   = 1'b0;
        pix     = s_data;

        case (state)
            ST_IDLE: begin
                if (acc && s_sof) begin
                    step    = 1'b1;
                    restart = 1'b1;
                end
            end
            ST_FILL, ST_RUN: begin
                if (acc) begin
                    step = 1'b1;
                    if (s_sof) begin
                        restart = 1'b1;
                        err_n   = (row != '0) || (col != '0);
                    end
                end
            end
`ifdef GAUSS_FLUSH_EN
            ST_FLUSH: begin
                step = 1'b1;
                pix  = '0;
            end
`endif
            default: ;
        endcase

        // A start-of-frame pixel is always processed as (0,0) in FILL.
        eff_state = restart ? ST_FILL : state;
        eff_row   = restart ? '0 : row;
        eff_col   = restart ? '0 : col;
        eff_wp    = restart ? '0 : wp;
        col_last  = (eff_col == COL_LAST);

        win_n   = step && (eff_row >= ROW_WIN_MIN) && (eff_col >= COL_WIN_MIN);
        cen_row = RW'(eff_row - RXW'(2));
        cen_col = eff_col - CW'(2);
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        wp_n    = wp;
        done_n  = 1'b0;

        if (step) begin
            state_n = eff_state;
            col_n   = col_last ? '0 : eff_col + CW'(1);
            row_n   = col_last ? eff_row + RXW'(1) : eff_row;
            wp_n    = col_last ? eff_wp + 2'd1 : eff_wp;

            if (col_last) begin
                case (eff_state)
                    ST_FILL: begin
                        if (eff_row == ROW_FILL_LAST) begin
                            state_n = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (eff_row == ROW_LAST) begin
`ifdef GAUSS_FLUSH_EN
                            // Counters keep running into virtual rows H, H+1.
                            state_n = ST_FLUSH;
`else
                            state_n = ST_IDLE;
                            row_n   = '0;
                            wp_n    = '0;
                            done_n  = 1'b1;
`endif
                        end
                    end
`ifdef GAUSS_FLUSH_EN
                    ST_FLUSH: begin
                        if (eff_row == ROW_FLUSH_LAST) begin
                            state_n = ST_IDLE;
                            row_n   = '0;
                            wp_n    = '0;
                            done_n  = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            wp         <= '0;
            tap_wp     <= '0;
            tap_valid  <= 1'b0;
            din5       <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_n;
            row        <= row_n;
            col        <= col_n;
            wp         <= wp_n;
            tap_valid  <= step;
            frame_done <= done_n;
            sync_err   <= err_n;
            win_valid  <= win_n;
            win_row    <= win_n ? cen_row : '0;
            win_col    <= win_n ? cen_col : '0;
            if (step) begin
                din5   <= pix;
                tap_wp <= eff_wp;
            end
        end
    end

    // All four RAMs are read every tap; only RAM[wp] is written. During
    // flush zeros are written so the first virtual row pads the second.
    for (genvar i = 0; i < 4; i++) begin : g_line
        gauss_line_ram #(
            .WIDTH (WIDTH),
            .DEPTH (PIC_WIDTH),
            .AW    (CW)
        ) u_line_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .re    (step),
            .raddr (eff_col),
            .we    (step && (eff_wp == 2'(i))),
            .waddr (eff_col),
            .wdata (pix),
            .rdata (rd_data[i])
        );
    end

    // RAM[wp] still holds row r-4; the others follow the ring backwards.
    assign din1 = rd_data[tap_wp];
    assign din2 = rd_data[tap_wp + 2'd1];
    assign din3 = rd_data[tap_wp + 2'd2];
    assign din4 = rd_data[tap_wp + 2'd3];

endmodule

// File: tb/tb_gauss5_window_ctrl.sv
// tb_gauss5_window_ctrl
// Directed bench for gauss5_window_ctrl with an 8x6 picture and pixels
// {row, col, 8'hA5}. Honours GAUSS_FLUSH_EN when compiled with it.

module tb_gauss5_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 3;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid, s_ready, s_sof;
    logic [23:0]   s_data;
    logic          tap_valid, win_valid, frame_done, sync_err;
    logic [23:0]   din1, din2, din3, din4, din5;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    int n_checks = 0;
    int n_pass   = 0;
    int win_cnt  = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    gauss5_window_ctrl #(
        .WIDTH      (24),
        .PIC_WIDTH  (W),
        .PIC_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .tap_valid  (tap_valid),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din4       (din4),
        .din5       (din5),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    function automatic logic [23:0] pix(input int r, input int c);
        return {8'(r), 8'(c), 8'hA5};
    endfunction

    // Rows at or beyond H are the zero padding written during flush.
    function automatic logic [23:0] rowpix(input int r, input int c);
        return (r >= H) ? 24'h0 : pix(r, c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a negedge: apply inputs, advance to the next negedge.
    task automatic clk_step(input logic v, input logic sof, input logic [23:0] d);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        @(negedge clk);
    endtask

    task automatic exp_tap(input int r, input int c, input bit zero5,
                           input bit ed, input bit ee);
        string t;
        bit    wv;
        t  = $sformatf("r%0d_c%0d", r, c);
        wv = (r >= 4) && (c >= 4);
        chk({t, " tap_valid"}, 32'(tap_valid), 32'd1);
        chk({t, " din5"}, 32'(din5), 32'(zero5 ? 24'h0 : pix(r, c)));
        if (r >= 4) begin
            chk({t, " din1"}, 32'(din1), 32'(rowpix(r - 4, c)));
            chk({t, " din2"}, 32'(din2), 32'(rowpix(r - 3, c)));
            chk({t, " din3"}, 32'(din3), 32'(rowpix(r - 2, c)));
            chk({t, " din4"}, 32'(din4), 32'(rowpix(r - 1, c)));
        end
        chk({t, " win_valid"}, 32'(win_valid), 32'(wv));
        chk({t, " win_row"}, 32'(win_row), 32'(wv ? r - 2 : 0));
        chk({t, " win_col"}, 32'(win_col), 32'(wv ? c - 2 : 0));
        chk({t, " frame_done"}, 32'(frame_done), 32'(ed));
        chk({t, " sync_err"}, 32'(sync_err), 32'(ee));
        if (win_valid === 1'b1) win_cnt++;
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " tap_valid"}, 32'(tap_valid), 32'd0);
        chk({tag, " win_valid"}, 32'(win_valid), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, " sync_err"}, 32'(sync_err), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " s_ready"}, 32'(s_ready), 32'd1);
        chk({tag, " din1"}, 32'(din1), 32'd0);
        chk({tag, " din2"}, 32'(din2), 32'd0);
        chk({tag, " din3"}, 32'(din3), 32'd0);
        chk({tag, " din4"}, 32'(din4), 32'd0);
        chk({tag, " din5"}, 32'(din5), 32'd0);
        chk({tag, " win_row"}, 32'(win_row), 32'd0);
        chk({tag, " win_col"}, 32'(win_col), 32'd0);
        check_quiet(tag);
    endtask

    task automatic send(input int r, input int c, input bit sof, input bit ed, input bit ee);
        chk($sformatf("r%0d_c%0d s_ready", r, c), 32'(s_ready), 32'd1);
        clk_step(1'b1, sof, pix(r, c));
        exp_tap(r, c, 1'b0, ed, ee);
    endtask

    task automatic gap();
        clk_step(1'b0, 1'b0, 24'hDEAD00);
        check_quiet("gap");
    endtask

    // Sends pixels from (0,0) up to but excluding (rl,cl).
    task automatic partial(input int rl, input int cl);
        for (int r = 0; r <= rl; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rl && c == cl) return;
                send(r, c, (r == 0 && c == 0), 1'b0, 1'b0);
            end
        end
    endtask

    task automatic run_frame(input bit gaps, input bit first_err);
        int  w0, d0;
        bit  last, ed;
        w0 = win_cnt;
        d0 = done_cnt;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 1) == 1) gap();
                last = (r == H - 1) && (c == W - 1);
`ifdef GAUSS_FLUSH_EN
                ed = 1'b0;
`else
                ed = last;
`endif
                send(r, c, (r == 0 && c == 0), ed, (r == 0 && c == 0) ? first_err : 1'b0);
            end
        end
`ifdef GAUSS_FLUSH_EN
        for (int i = 0; i < 2 * W; i++) begin
            chk($sformatf("flush%0d s_ready", i), 32'(s_ready), 32'd0);
            clk_step(1'b0, 1'b0, 24'h0);
            exp_tap(H + i / W, i % W, 1'b1, (i == 2 * W - 1), 1'b0);
        end
        chk("frame windows", 32'(win_cnt - w0), 32'((H - 2) * (W - 4)));
`else
        chk("frame windows", 32'(win_cnt - w0), 32'((H - 4) * (W - 4)));
`endif
        chk("frame done count", 32'(done_cnt - d0), 32'd1);
        chk("idle s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        int d0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // IDLE drops pixels without s_sof.
        for (int i = 0; i < 3; i++) begin
            clk_step(1'b1, 1'b0, pix(1, i));
            check_quiet("idle_drop");
        end
        clk_step(1'b0, 1'b0, 24'h0);

        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);

        // s_sof where (2,3) was expected: resync, aborted frame never completes.
        d0 = done_cnt;
        partial(2, 3);
        run_frame(1'b0, 1'b1);
        chk("abort done count", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset in the middle of row 3.
        partial(3, 4);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clk_step(1'b1, 1'b0, pix(0, 0));
        check_quiet("post_reset_drop");
        clk_step(1'b0, 1'b0, 24'h0);
        run_frame(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
